// File: rtl/lut_ram_ctrl.sv
// Init sweep and two-client round-robin arbiter in front of a LUT_ram
// (synchronous write port, asynchronous read port).
module lut_ram_ctrl #(
  parameter  int unsigned W  = 32,
  parameter  int unsigned D  = 8,
  localparam int unsigned AW = $clog2(D)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [1:0]        req,
  input  logic [1:0]        req_we,
  input  logic [2*AW-1:0]   req_addr,
  input  logic [2*W-1:0]    req_wdata,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [W-1:0]      rdata,
  output logic              init_done,
  output logic              ram_we,
  output logic [AW-1:0]     ram_waddr,
  output logic [W-1:0]      ram_wdata,
  output logic [AW-1:0]     ram_raddr,
  input  logic [W-1:0]      ram_rdata
);

  typedef enum logic [1:0] {START, INIT, ARB} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [1:0]      rvalid_q, rvalid_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic            init_done_q, init_done_d;

  logic            win;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [W-1:0]    win_wdata;

  // Winner: a lone requester, or on a tie the client not granted last
  always_comb begin
    win       = (req == 2'b10) || ((req == 2'b11) && !last_q);
    win_we    = win ? req_we[1] : req_we[0];
    win_addr  = win ? req_addr[AW +: AW] : req_addr[0 +: AW];
    win_wdata = win ? req_wdata[W +: W]  : req_wdata[0 +: W];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    rvalid_d    = 2'b00;
    rdata_d     = rdata_q;
    init_done_d = init_done_q;
    gnt         = 2'b00;
    ram_we      = 1'b0;
    ram_waddr   = '0;
    ram_wdata   = '0;
    ram_raddr   = '0;
    unique case (state_q)
      START: begin
        state_d = INIT;
        cnt_d   = '0;
      end
      INIT: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == AW'(D - 1)) begin
          state_d     = ARB;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      ARB: begin
        if (clear) begin
          state_d     = INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else if (|req) begin
          gnt[win] = 1'b1;
          last_d   = win;
          if (win_we) begin
            ram_we    = 1'b1;
            ram_waddr = win_addr;
            ram_wdata = win_wdata;
          end else begin
            ram_raddr     = win_addr;
            rvalid_d[win] = 1'b1;
            rdata_d       = ram_rdata;
          end
        end
      end
      default: state_d = START;
    endcase
  end

  // last_q resets to 1 so client 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= START;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lut_ram_ctrl.sv
// Scoreboard bench for lut_ram_ctrl: directed scenarios then random traffic,
// checked against a phase/round-robin model with its own memory image.
module tb_lut_ram_ctrl;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = $clog2(D);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic [1:0]        req = '0;
  logic [1:0]        req_we = '0;
  logic [2*AW-1:0]   req_addr = '0;
  logic [2*W-1:0]    req_wdata = '0;
  logic [1:0]        gnt, rvalid;
  logic [W-1:0]      rdata;
  logic              init_done, ram_we;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [W-1:0]      ram_wdata, ram_rdata;

  lut_ram_ctrl #(.W(W), .D(D)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .init_done(init_done), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Stand-in LUT_ram: synchronous write, asynchronous read
  logic [W-1:0] ram_m [D];
  always @(posedge clk) if (ram_we) ram_m[ram_waddr] <= ram_wdata;
  assign ram_rdata = ram_m[ram_raddr];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Client request state (held until granted)
  logic          pend [2];
  logic          op_we [2];
  logic [AW-1:0] op_addr [2];
  logic [W-1:0]  op_data [2];

  // Reference: p = 0 START, 1..D zeroing address p-1, D+1 arbitrating
  int           p;
  logic         last_m;
  logic [W-1:0] ref_mem [D];

  typedef struct {int due; int cl; logic [W-1:0] data;} exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_op(input int c, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    pend[c] = 1'b1; op_we[c] = we; op_addr[c] = a; op_data[c] = d;
  endtask

  task automatic drive_inputs();
    req       = {pend[1], pend[0]};
    req_we    = {op_we[1], op_we[0]};
    req_addr  = {op_addr[1], op_addr[0]};
    req_wdata = {op_data[1], op_data[0]};
  endtask

  task automatic check_and_predict();
    logic [1:0]    eg;
    logic          ewe;
    logic [AW-1:0] ewa, era;
    logic [W-1:0]  ewd;
    int            w;
    eg = '0; ewe = 1'b0; ewa = '0; era = '0; ewd = '0; w = -1;
    if (p >= 1 && p <= int'(D)) begin
      ewe = 1'b1;
      ewa = AW'(p - 1);
    end else if (p == int'(D) + 1 && !clear) begin
      if (pend[0] && pend[1]) w = last_m ? 0 : 1;
      else if (pend[0])       w = 0;
      else if (pend[1])       w = 1;
      if (w >= 0) begin
        eg[w] = 1'b1;
        if (op_we[w]) begin ewe = 1'b1; ewa = op_addr[w]; ewd = op_data[w]; end
        else era = op_addr[w];
      end
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("ram_we", 64'(ram_we), 64'(ewe));
    chk("ram_waddr", 64'(ram_waddr), 64'(ewa));
    chk("ram_wdata", 64'(ram_wdata), 64'(ewd));
    chk("ram_raddr", 64'(ram_raddr), 64'(era));
    chk("init_done", 64'(init_done), 64'(p == int'(D) + 1));
    if (w >= 0) begin
      if (op_we[w]) ref_mem[op_addr[w]] = op_data[w];
      else q.push_back('{cyc + 1, w, ref_mem[op_addr[w]]});
      last_m  = (w == 1);
      pend[w] = 1'b0;
    end
    if (p >= 1 && p <= int'(D)) ref_mem[p-1] = '0;
  endtask

  task automatic advance();
    if (p <= int'(D)) p++;
    else if (clear) p = 1;
  endtask

  task automatic step();
    drive_inputs();
    @(negedge clk);
    check_and_predict();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    p = 0;
    last_m = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    drive_inputs();
    check_and_predict();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pend[0] || pend[1]) && n < 100) begin step(); n++; end
    if (pend[0] || pend[1]) begin
      tests++; fails++;
      $display("FAIL grant_timeout: got no grant after %0d cycles, required a grant", n);
      pend[0] = 1'b0; pend[1] = 1'b0;
    end
    step(); step();
  endtask

  // Monitor: every cycle either the oldest expected read is due, or rvalid is idle
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("rvalid", 64'(rvalid), (e.cl == 0) ? 64'd1 : 64'd2);
        chk("rdata", 64'(rdata), 64'(e.data));
      end else begin
        chk("rvalid_idle", 64'(rvalid), 64'd0);
      end
    end
  end

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    op_we[0] = 1'b0; op_we[1] = 1'b0;
    op_addr[0] = '0; op_addr[1] = '0;
    op_data[0] = '0; op_data[1] = '0;
    p = 0; last_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Reset in the middle of the sweep (cnt = 4), then sweep with both clients requesting
    while (p != 5) step();
    set_op(0, 1'b0, AW'(0), '0);
    set_op(1, 1'b0, AW'(1), '0);
    do_reset();
    wait_idle();

    // Single client write then read
    set_op(0, 1'b1, AW'(2), 32'hDEADBEEF); wait_idle();
    set_op(0, 1'b0, AW'(2), '0);          wait_idle();
    set_op(1, 1'b1, AW'(5), 32'hCAFEBABE); wait_idle();

    // Continuous contention
    for (int i = 0; i < 8; i++) begin
      if (!pend[0]) set_op(0, 1'b0, AW'(2), '0);
      if (!pend[1]) set_op(1, 1'b0, AW'(5), '0);
      step();
    end
    wait_idle();

    // Clear sweep with client 0 holding a read of 5
    set_op(0, 1'b0, AW'(5), '0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    wait_idle();

    // Same-address race fresh after init
    do_reset();
    set_op(0, 1'b0, AW'(3), '0);
    set_op(1, 1'b1, AW'(3), 32'h12345678);
    wait_idle();
    set_op(0, 1'b0, AW'(3), '0);
    wait_idle();

    // Random traffic with occasional clear pulses
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 2; c++)
        if (!pend[c] && $urandom_range(0, 2) != 0)
          set_op(c, 1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)), W'($urandom));
      clear = ($urandom_range(0, 49) == 0);
      step();
    end
    clear = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lut_ram_ctrl.md
# lut_ram_ctrl

Two-client arbiter and initialisation sequencer for the `LUT_ram` distributed-RAM block (one synchronous write port, one asynchronous read port). After reset, and on request, it sweeps every location to zero, then shares the RAM between two requesters. Arbitration is round-robin, with one access per cycle and a registered read response. It sits between the RAM instance and its clients; the RAM's ports are driven only by this block.

## Interface
- `W`, 32, data width (matches `LUT_ram` `W`)
- `D`, 8, RAM depth in words; D ≥ 2
- `AW`, `$clog2(D)`, address width (derived, not overridden)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `clear`  in  1  level; sampled in ARB, starts a zero sweep
- `req`  in  2  per-client request; bit i = client i
- `req_we`  in  2  per-client op: 1 = write, 0 = read
- `req_addr`  in  2*AW  client i address at `[i*AW +: AW]`
- `req_wdata`  in  2*W  client i write data at `[i*W +: W]`
- `gnt`  out  2  one-hot grant; combinational, access happens this cycle
- `rvalid`  out  2  registered; pulses one cycle on the bit of the granted reader
- `rdata`  out  W  registered read data; valid when any `rvalid` bit is set
- `init_done`  out  1  registered; high in ARB only
- `ram_we`  out  1  to `LUT_ram.write_en`
- `ram_waddr`  out  AW  to `LUT_ram.write_addr`
- `ram_wdata`  out  W  to `LUT_ram.data_in`
- `ram_raddr`  out  AW  to `LUT_ram.read_addr`
- `ram_rdata`  in  W  from `LUT_ram.out` (combinational read)

## Operation
- FSM states: START, INIT, ARB. Reset state is START.
- START: one cycle. All RAM outputs are 0. Goes to INIT with `cnt`=0.
- INIT:
  - `ram_we`=1, `ram_waddr`=`cnt`, `ram_wdata`=0. `gnt`=0 regardless of `req`.
  - `cnt` increments each edge.
  - When `cnt`=D-1, the next edge moves to ARB and sets `init_done`=1.
  - `clear` is ignored in INIT.
- ARB, `clear`=0:
  - Winner selection:
    - Only one `req` bit set: that client wins.
    - Both set: the client not granted most recently wins.
    - The `last` pointer updates only on a grant.
  - `gnt[win]`=1.
  - Winner's op is a write: `ram_we`=1, `ram_waddr`/`ram_wdata` come from the winner.
  - Winner's op is a read: `ram_raddr`=winner's address. At the edge, `rdata` captures `ram_rdata` and `rvalid[win]`=1 for one cycle.
- ARB, `clear`=1: no grant that cycle. Next edge sets `init_done`=0, `cnt`=0 and moves to INIT.
- Idle outputs: when no write is granted, `ram_we`=0, `ram_waddr`=0, `ram_wdata`=0. `ram_raddr`=0 when no read is granted.
- Requester protocol:
  - Client holds `req` and its fields stable until it sees `gnt` at a rising edge.
  - It may drop `req`, or present a new op, the following cycle.
- Only one RAM access occurs per cycle, so there is no same-cycle read/write hazard between clients.

## Timing
- Reset values (async, while `rst_n`=0): state=START, `cnt`=0, `last`=1 (client 0 wins the first tie), `rvalid`=0, `rdata`=0, `init_done`=0. `gnt`=0 and `ram_we`=0 follow combinationally.
- After `rst_n` rises, `init_done`=1 after exactly D+1 rising edges (9 for D=8).
- Read latency: 1 cycle from the grant edge to `rvalid`/`rdata`.
- Write: RAM is updated at the grant edge. A read granted on a later cycle returns the new data.
- Back-to-back grants are allowed every cycle. Under continuous contention, grants alternate 0,1,0,1…
- `clear` sweep: D+1 cycles of no grants (one ARB cycle plus D INIT cycles).
- Reset mid-INIT or mid-ARB:
  - All state is reset immediately. A pending `rvalid` is lost.
  - The full START→INIT sweep reruns.
- `rdata` holds its last value when `rvalid`=0.

## Test plan
- Reset/init, D=8, `req`=2'b11 held:
  - `ram_we`=1 for 8 cycles at addresses 0..7 with data 0.
  - `gnt`=0 throughout.
  - `init_done` rises on the 9th edge.
  - First grant goes to client 0.
- Single client: client 0 writes 0xDEADBEEF to address 2, then reads address 2 -> `gnt`=01 on each; `rvalid`=01 one cycle after the read grant; `rdata`=0xDEADBEEF.
- Contention: both clients issue continuous reads (client 0 of address 2, client 1 of address 5, after writing 0xCAFEBABE to 5) -> `gnt` sequence 01,10,01,10; `rdata` alternates 0xDEADBEEF/0xCAFEBABE with matching `rvalid` bit.
- Same-address race, fresh after init: client 0 reads 3 and client 1 writes 0x12345678 to 3, requested together:
  - Client 0 granted first; `rdata`=0.
  - Client 1 write granted next.
  - Client 0 re-reads 3 -> 0x12345678.
- Clear: in ARB after writing 5=0xCAFEBABE, pulse `clear` with `req`=01 held:
  - `init_done` falls and there are no grants for 9 cycles.
  - Read of 5 then returns 0.
- Reset mid-init: drop `rst_n` when `cnt`=4:
  - `ram_we`=0, `init_done`=0, `rvalid`=0 immediately.
  - After release, the sweep restarts at address 0 and `init_done` rises after 9 edges.
